// File: rtl/ets_phase_stepper_if.sv
// ets_phase_stepper_if
//   Request handshake and DCM phase-shift signals of the ETS phase stepper.
//   master : requester / DCM side (drives req_valid, req_target, ps_done)
//   slave  : ets_phase_stepper   (drives req_ready, ps_en, ps_incdec)
//   req_valid  - target request valid
//   req_ready  - stepper idle and able to accept
//   req_target - requested phase position, unsigned DCM fine-phase steps
//   ps_en      - DCM PSEN, single-cycle pulses
//   ps_incdec  - DCM PSINCDEC, 1 = increment
//   ps_done    - DCM PSDONE
interface ets_phase_stepper_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_target;
  logic       ps_en;
  logic       ps_incdec;
  logic       ps_done;

  modport master (
    output req_valid, req_target, ps_done,
    input  req_ready, ps_en, ps_incdec
  );

  modport slave (
    input  req_valid, req_target, ps_done,
    output req_ready, ps_en, ps_incdec
  );
endinterface

// File: rtl/ets_phase_stepper.sv
// ets_phase_stepper
//   Walks the variable-phase DCM one fine-phase step at a time toward a
//   requested position, waits for PSDONE after every PSEN pulse, and pulses
//   done once the sampling clock has settled at the target.
// Ports:
//   ref_clk   - sole clock (also DCM PSCLK)
//   rst_n     - synchronous active-low reset
//   dcm_lock  - DCM LOCKED; loss forces a return to WAIT_LOCK at phase 0
//   ps_if     - request handshake + DCM PSEN/PSINCDEC/PSDONE (slave modport)
//   cur_phase - tracked DCM phase position
//   busy      - high outside IDLE and WAIT_LOCK
//   done      - one-cycle pulse: target reached and settled
//   phase_err - sticky error, cleared on request accept
// Build option:
//   ETS_PS_TIMEOUT_EN - abort a step when PSDONE does not arrive within
//                       TIMEOUT_CYCLES cycles of WAIT_DONE.
module ets_phase_stepper #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic               ref_clk,
  input  logic               rst_n,
  input  logic               dcm_lock,
  ets_phase_stepper_if.slave ps_if,
  output logic [7:0]         cur_phase,
  output logic               busy,
  output logic               done,
  output logic               phase_err
);

  if (SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("ets_phase_stepper: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
  end

`ifdef ETS_PS_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam int unsigned CNT_W = 8;
`endif
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    IDLE,
    STEP,
    WAIT_DONE,
    SETTLE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cur_phase_q, cur_phase_d;
  logic [7:0]       target_q, target_d;
  logic             incdec_q, incdec_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       next_phase;

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      cur_phase_q <= '0;
      target_q    <= '0;
      incdec_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_phase_q <= cur_phase_d;
      target_q    <= target_d;
      incdec_q    <= incdec_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_phase_d = cur_phase_q;
    target_d    = target_q;
    incdec_d    = incdec_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    next_phase  = incdec_q ? (cur_phase_q + 8'd1) : (cur_phase_q - 8'd1);

    unique case (state_q)
      WAIT_LOCK: begin
        if (dcm_lock) state_d = IDLE;
      end
      IDLE: begin
        if (ps_if.req_valid) begin
          target_d = ps_if.req_target;
          err_d    = 1'b0;
          cnt_d    = '0;
          // Direction is fixed for the whole walk, so the count is monotonic.
          incdec_d = (ps_if.req_target > cur_phase_q);
          state_d  = (ps_if.req_target == cur_phase_q) ? SETTLE : STEP;
        end
      end
      STEP: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ps_if.ps_done) begin
          cur_phase_d = next_phase;
          cnt_d       = '0;
          state_d     = (next_phase == target_q) ? SETTLE : STEP;
        end
`ifdef ETS_PS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LIM) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LIM) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides everything decided above, including an accept in
    // IDLE (so the accept's error clear is undone as well).
    if (state_q != WAIT_LOCK && !dcm_lock) begin
      state_d     = WAIT_LOCK;
      cur_phase_d = '0;
      target_d    = target_q;
      incdec_d    = incdec_q;
      cnt_d       = cnt_q;
      done        = 1'b0;
      err_d       = (state_q == STEP || state_q == WAIT_DONE || state_q == SETTLE) ? 1'b1 : err_q;
    end
  end

  assign ps_if.req_ready = (state_q == IDLE);
  assign ps_if.ps_en     = (state_q == STEP);
  assign ps_if.ps_incdec = incdec_q;
  assign cur_phase       = cur_phase_q;
  assign busy            = (state_q != IDLE) && (state_q != WAIT_LOCK);
  assign phase_err       = err_q;

endmodule

// File: tb/tb_ets_phase_stepper.sv
// tb_ets_phase_stepper
//   Drives ets_phase_stepper with directed and randomized phase requests
//   against a behavioural DCM responder; expectations come from a
//   transaction-level model (step count = |target - phase|, fixed
//   direction, done SETTLE_CYCLES+1 cycles after the last PSDONE/accept).
module tb_ets_phase_stepper;
  localparam int S  = 5;
  localparam int TO = 8;

  logic       ref_clk = 1'b0;
  logic       rst_n;
  logic       dcm_lock;
  logic [7:0] cur_phase;
  logic       busy;
  logic       done;
  logic       phase_err;
  logic       dcm_done = 1'b0;
  logic       spur = 1'b0;

  ets_phase_stepper_if pif ();

  assign pif.ps_done = dcm_done | spur;

  ets_phase_stepper #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .dcm_lock (dcm_lock),
    .ps_if    (pif.slave),
    .cur_phase(cur_phase),
    .busy     (busy),
    .done     (done),
    .phase_err(phase_err)
  );

  always #5 ref_clk = ~ref_clk;

  int total = 0;
  int bad   = 0;

  // DCM responder / monitor state
  int   en_cnt = 0;
  int   done_cnt = 0;
  int   b2b_err = 0;
  int   last_psdone_cyc = 0;
  int   last_done_cyc = 0;
  int   dcm_lat = 4;
  int   dcm_cd = 0;
  bit   dcm_mute = 1'b0;
  bit   prev_en = 1'b0;
  logic dir_q[$];

  // Reference model
  int model_phase = 0;

  function automatic int cyc_now();
    return int'($time / 10);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // DCM model: PSDONE dcm_lat cycles after each PSEN; also logs outputs.
  initial begin
    forever begin
      @(negedge ref_clk);
      if (pif.ps_en) begin
        en_cnt++;
        dir_q.push_back(pif.ps_incdec);
        if (prev_en) b2b_err++;
      end
      prev_en = pif.ps_en;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc_now();
      end
      dcm_done = 1'b0;
      if (dcm_cd > 0) begin
        dcm_cd--;
        if (dcm_cd == 0) begin
          dcm_done = 1'b1;
          last_psdone_cyc = cyc_now();
        end
      end
      if (pif.ps_en && !dcm_mute) dcm_cd = dcm_lat;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!pif.req_ready && n < 300) begin
      @(negedge ref_clk);
      n++;
    end
    check("ready_before_req", int'(pif.req_ready), 1);
  endtask

  task automatic do_req(input int t, input int lat, input bit poke);
    int  e0, d0, n, steps, acc_cyc, bad_dir, ref_cyc;
    bit  dir;
    dcm_lat = lat;
    wait_ready();
    e0 = en_cnt;
    d0 = done_cnt;
    dir_q.delete();
    steps = (t > model_phase) ? (t - model_phase) : (model_phase - t);
    dir   = (t > model_phase);
    pif.req_valid  = 1'b1;
    pif.req_target = t[7:0];
    acc_cyc = cyc_now();
    @(negedge ref_clk);
    pif.req_valid = 1'b0;
    check("err_clear_on_accept", int'(phase_err), 0);
    check("ready_low_after_accept", int'(pif.req_ready), 0);
    if (poke) begin
      repeat (3) @(negedge ref_clk);
      check("busy_at_poke", int'(busy), 1);
      pif.req_valid  = 1'b1;
      pif.req_target = 8'((t ^ 85) & 255);
      @(negedge ref_clk);
      pif.req_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < steps * (lat + 2) + S + 40) begin
      @(negedge ref_clk);
      n++;
    end
    repeat (2) @(negedge ref_clk);
    check("step_count", en_cnt - e0, steps);
    bad_dir = 0;
    foreach (dir_q[i]) if (dir_q[i] !== dir) bad_dir++;
    check("step_direction", bad_dir, 0);
    check("phase_final", int'(cur_phase), t);
    check("done_count", done_cnt - d0, 1);
    ref_cyc = (steps > 0) ? last_psdone_cyc : acc_cyc;
    check("done_latency", last_done_cyc - ref_cyc, S + 1);
    check("ready_after_done", int'(pif.req_ready), 1);
    check("busy_after_done", int'(busy), 0);
    model_phase = t;
  endtask

  initial begin
    int n, d0, e0, t;
    rst_n          = 1'b0;
    dcm_lock       = 1'b0;
    pif.req_valid  = 1'b0;
    pif.req_target = '0;
    repeat (3) @(negedge ref_clk);
    check("rst_ps_en", int'(pif.ps_en), 0);
    check("rst_incdec", int'(pif.ps_incdec), 0);
    check("rst_ready", int'(pif.req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(phase_err), 0);
    check("rst_phase", int'(cur_phase), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge ref_clk);
    check("ready_no_lock", int'(pif.req_ready), 0);
    dcm_lock = 1'b1;
    @(negedge ref_clk);
    check("ready_after_lock", int'(pif.req_ready), 1);

    do_req(3, 4, 1'b0);
    do_req(1, 4, 1'b0);
    do_req(1, 4, 1'b0);

    // Spurious PSDONE while idle must not move the phase.
    @(negedge ref_clk);
    spur = 1'b1;
    @(negedge ref_clk);
    spur = 1'b0;
    repeat (2) @(negedge ref_clk);
    check("spurious_phase", int'(cur_phase), model_phase);
    check("spurious_ready", int'(pif.req_ready), 1);

    do_req(10, 3, 1'b1);

    // Lock loss mid-walk.
    dcm_lat = 4;
    wait_ready();
    d0 = done_cnt;
    pif.req_valid  = 1'b1;
    pif.req_target = 8'd200;
    @(negedge ref_clk);
    pif.req_valid = 1'b0;
    n = 0;
    while (cur_phase != 8'd50 && n < 600) begin
      @(negedge ref_clk);
      n++;
    end
    check("walk_reached_50", int'(cur_phase), 50);
    dcm_lock = 1'b0;
    @(negedge ref_clk);
    check("lockloss_phase", int'(cur_phase), 0);
    check("lockloss_err", int'(phase_err), 1);
    check("lockloss_busy", int'(busy), 0);
    check("lockloss_ready", int'(pif.req_ready), 0);
    repeat (10) @(negedge ref_clk);
    check("lockloss_no_done", done_cnt - d0, 0);
    check("lockloss_phase_hold", int'(cur_phase), 0);
    dcm_lock = 1'b1;
    @(negedge ref_clk);
    check("relock_ready", int'(pif.req_ready), 1);
    model_phase = 0;
    do_req(2, 4, 1'b0);

    // Randomized requests, some equal to the current phase.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) t = model_phase;
      else t = int'($urandom_range(0, 255));
      do_req(t, int'($urandom_range(1, 5)), ($urandom_range(0, 1) == 1));
    end

    // Lock loss while idle: phase returns to 0 but no error.
    @(negedge ref_clk);
    dcm_lock = 1'b0;
    @(negedge ref_clk);
    check("idle_lockloss_phase", int'(cur_phase), 0);
    check("idle_lockloss_err", int'(phase_err), 0);
    dcm_lock = 1'b1;
    model_phase = 0;
    do_req(7, 2, 1'b0);

`ifdef ETS_PS_TIMEOUT_EN
    dcm_mute = 1'b1;
    wait_ready();
    e0 = en_cnt;
    d0 = done_cnt;
    pif.req_valid  = 1'b1;
    pif.req_target = 8'(model_phase + 1);
    @(negedge ref_clk);
    pif.req_valid = 1'b0;
    repeat (TO) @(negedge ref_clk);
    check("timeout_not_yet", int'(pif.req_ready), 0);
    @(negedge ref_clk);
    check("timeout_ready", int'(pif.req_ready), 1);
    check("timeout_err", int'(phase_err), 1);
    check("timeout_phase", int'(cur_phase), model_phase);
    check("timeout_pulses", en_cnt - e0, 1);
    repeat (3) @(negedge ref_clk);
    check("timeout_no_done", done_cnt - d0, 0);
    dcm_mute = 1'b0;
    do_req(model_phase + 2, 3, 1'b0);
`endif

    check("ps_en_single_cycle", b2b_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ets_phase_stepper.md
# ets_phase_stepper

Phase-step sequencer for the equivalent-time-sampling clock path. It accepts a target phase position (0–255 DCM fine-phase steps) from the capture controller. It walks the variable-phase DCM toward that position one step at a time with single-cycle PSEN pulses, waiting for each PSDONE. It reports when the sampling clock has settled at the requested offset. It sits directly upstream of the ETS clock generator, driving its phase-shift enable/direction inputs in the `ref_clk` domain.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: `ref_clk` cycles to wait after reaching target before `done` pulses; range 0–255.
- `TIMEOUT_CYCLES`, 1023: max cycles to wait for `ps_done` per step; only used with `ETS_PS_TIMEOUT_EN`.

Ports:
- `ref_clk`  in  1  sole clock; also the DCM PSCLK.
- `rst_n`  in  1  synchronous, active-low reset.
- `dcm_lock`  in  1  DCM LOCKED.
- `req_valid`  in  1  target request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_target`  in  8  requested phase position, unsigned steps.
- `ps_en`  out  1  to DCM PSEN; one-cycle pulses.
- `ps_incdec`  out  1  to DCM PSINCDEC; 1 = increment.
- `ps_done`  in  1  DCM PSDONE.
- `cur_phase`  out  8  tracked DCM phase position.
- `busy`  out  1  high in any state except IDLE and WAIT_LOCK.
- `done`  out  1  one-cycle pulse: target reached and settled.
- `phase_err`  out  1  sticky error flag.

## Operation
States: WAIT_LOCK, IDLE, STEP, WAIT_DONE, SETTLE.
- Reset: state WAIT_LOCK; `cur_phase`=0, `ps_en`=0, `ps_incdec`=0, `req_ready`=0, `busy`=0, `done`=0, `phase_err`=0.
- WAIT_LOCK → IDLE when `dcm_lock`=1.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_target` and clear `phase_err`.
  - If target == `cur_phase`, go to SETTLE.
  - Otherwise go to STEP.
- STEP: `ps_en`=1 for exactly this cycle. `ps_incdec`=(target > `cur_phase`), held stable until the step completes. Next state: WAIT_DONE.
- WAIT_DONE: on `ps_done`=1, `cur_phase` ±1 per direction.
  - If the new value == target, go to SETTLE.
  - Otherwise go to STEP.
- SETTLE: count `SETTLE_CYCLES` cycles, then pulse `done` for 1 cycle and go to IDLE.
- `ps_done` is sampled only in WAIT_DONE; pulses in any other state are ignored.
- `cur_phase` never wraps. The direction is chosen so the count moves monotonically toward the target; 0→255 takes 255 increments.
- Lock loss: `dcm_lock`=0 in any state other than WAIT_LOCK has these effects next cycle:
  - state → WAIT_LOCK, `cur_phase` → 0 (the DCM relocks at phase 0);
  - `phase_err` set if the state was STEP, WAIT_DONE or SETTLE;
  - no `done` pulse; any pending request is dropped.
- Requests arriving while `req_ready`=0 are not accepted. The requester holds `req_valid` until accepted.

## Timing
- Accept at edge N → `ps_en` high in cycle N+1.
- `ps_done` seen at edge M → `cur_phase` updated at M. The next `ps_en` (if any) is high in cycle M+1.
- Minimum step period: 2 cycles plus DCM PSDONE latency.
- Target reached at edge M → `done` high in cycle M+1+`SETTLE_CYCLES`; `req_ready` high the cycle after `done`.
- Target == `cur_phase` at accept edge N → `done` in cycle N+1+`SETTLE_CYCLES`.
- Lock loss has priority over `ps_done`, settle completion and request acceptance in the same cycle.

## Configuration
- `ETS_PS_TIMEOUT_EN` defined:
  - WAIT_DONE runs a cycle counter, cleared on entry.
  - If it reaches `TIMEOUT_CYCLES` without `ps_done`: set `phase_err`, leave `cur_phase` unchanged, go to IDLE with no `done` pulse.
- Undefined: no counter logic; WAIT_DONE waits indefinitely for `ps_done` or lock loss.

## Test plan
- Reset with `dcm_lock`=0 → all outputs 0, `req_ready`=0. Raise lock → `req_ready`=1 the next cycle.
- From `cur_phase`=0, request 3, DCM model returns `ps_done` 4 cycles after each `ps_en` → exactly 3 `ps_en` pulses, `ps_incdec`=1, `cur_phase`=3, one `done` pulse `SETTLE_CYCLES`+1 cycles after the third `ps_done`.
- From 3, request 1 → 2 pulses with `ps_incdec`=0, `cur_phase`=1. Request 1 again → zero `ps_en` pulses, `done` after `SETTLE_CYCLES`+1 cycles.
- Request 200, drop `dcm_lock` after the 50th step → `cur_phase`=0, `phase_err`=1, no `done`. Relock, request 2 → `phase_err` clears on accept, `done` follows normally.
- Spurious `ps_done` in IDLE, and `req_valid` pulsed while busy → `cur_phase` unchanged, request not accepted.
- With `ETS_PS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, withhold `ps_done` → `phase_err`=1 and IDLE after 8 cycles in WAIT_DONE, `cur_phase` unchanged, no `done`.
